// File: rtl/car_row_mover.sv
// -----------------------------------------------------------------------------
// car_row_mover
//
// Produces per-frame X/Y positions for one lane of traffic (up to four cars)
// for the VGA colour-mapping stage. Cars advance once per detected VGA frame
// and wrap horizontally using an 11-bit two's-complement off-screen range:
// X values in [-80, 639] are meaningful, with negative values just off the
// left edge of the 640-pixel-wide screen.
//
// Ports
//   Clk          in   system clock
//   Reset        in   asynchronous, active-high reset
//   frame_clk    in   VGA frame strobe, asynchronous to Clk (one rise/frame)
//   game_start   in   one-cycle pulse: reload start positions, enter RUN
//   pause        in   level: freeze motion while high
//   level        in   difficulty, sampled only on game_start
//   Car_X        out  [3:0][10:0] car X positions (two's complement)
//   Car_Y        out  [3:0][10:0] car Y positions
//   Number_Cars  out  cars to draw; 0 while idle
//   frame_tick   out  one-Clk pulse per detected frame_clk rise
//   running      out  high while in RUN
// -----------------------------------------------------------------------------
module car_row_mover #(
  parameter logic [2:0]  N_CARS     = 3'd4,
  parameter logic [10:0] ROW_Y      = 11'd400,
  parameter logic [10:0] START_X    = 11'd0,
  parameter logic [10:0] SPACING    = 11'd160,
  parameter logic [3:0]  BASE_SPEED = 4'd1,
  parameter logic        DIR_LEFT   = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_clk,
  input  logic             game_start,
  input  logic             pause,
  input  logic [1:0]       level,
  output logic [3:0][10:0] Car_X,
  output logic [3:0][10:0] Car_Y,
  output logic [2:0]       Number_Cars,
  output logic             frame_tick,
  output logic             running
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  // Screen geometry of the wrap convention.
  localparam logic signed [11:0] RIGHT_LIMIT = 12'sd640;
  localparam logic signed [11:0] LEFT_LIMIT  = -12'sd80;
  localparam logic [10:0]        OFF_LEFT_X  = 11'd1968;  // -80 in 11 bits
  localparam logic [10:0]        OFF_RIGHT_X = 11'd640;

  // Frame strobe synchroniser and edge detector.
  logic sync1_q, sync2_q, prev_q, tick_q;

  state_t             state_q, state_d;
  logic [4:0]         speed_q, speed_d;
  logic [3:0][10:0]   car_x_q, car_x_d;
  logic [3:0][10:0]   car_y_q, car_y_d;
  logic [2:0]         num_cars_q, num_cars_d;
  logic               running_q, running_d;

  // One motion step for a single car. The X value is widened to 12 bits with
  // its sign so the threshold compare cannot overflow.
  function automatic logic [10:0] step_x(input logic [10:0] x,
                                         input logic [4:0]  spd);
    logic signed [11:0] sx;
    logic signed [11:0] nx;
    sx = signed'({x[10], x});
    if (!DIR_LEFT) begin
      nx = sx + signed'({7'd0, spd});
      step_x = (nx >= RIGHT_LIMIT) ? OFF_LEFT_X : nx[10:0];
    end else begin
      nx = sx - signed'({7'd0, spd});
      step_x = (nx <= LEFT_LIMIT) ? OFF_RIGHT_X : nx[10:0];
    end
  endfunction

  // NOTE: every flop below is written with non-blocking assignments so all
  // registers update from the same pre-edge values, independent of order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      // Registered so the tick is a glitch-free single-cycle pulse.
      tick_q  <= sync2_q & ~prev_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      speed_q    <= 5'(BASE_SPEED);
      car_x_q    <= '0;
      car_y_q    <= '0;
      num_cars_q <= 3'd0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      speed_q    <= speed_d;
      car_x_q    <= car_x_d;
      car_y_q    <= car_y_d;
      num_cars_q <= num_cars_d;
      running_q  <= running_d;
    end
  end

  always_comb begin
    logic [10:0] start_acc;
    // NOTE: all outputs of this block get a default first, so no path can
    // leave a variable unassigned and infer a latch.
    state_d   = state_q;
    speed_d   = speed_q;
    car_x_d   = car_x_q;
    car_y_d   = car_y_q;
    start_acc = START_X;

    if (game_start) begin
      // Reload has priority over any motion due on the same cycle.
      state_d = S_RUN;
      speed_d = 5'(BASE_SPEED) + 5'(level);
      for (int i = 0; i < 4; i++) begin
        if (i < int'(N_CARS)) begin
          car_x_d[i] = start_acc;
          car_y_d[i] = ROW_Y;
        end else begin
          car_x_d[i] = 11'd0;
          car_y_d[i] = 11'd0;
        end
        start_acc = start_acc + SPACING;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          // Motion is taken from the RUN state even if pause rises on the
          // same cycle; the freeze starts from the following frame.
          if (tick_q) begin
            for (int i = 0; i < 4; i++) begin
              if (i < int'(N_CARS)) begin
                car_x_d[i] = step_x(car_x_q[i], speed_q);
              end
            end
          end
          if (pause) begin
            state_d = S_PAUSED;
          end
        end
        S_PAUSED: begin
          if (!pause) begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    // Status outputs follow the next state so they are registered together
    // with it and change on the same edge.
    num_cars_d = (state_d == S_IDLE) ? 3'd0 : N_CARS;
    running_d  = (state_d == S_RUN);
  end

  assign Car_X       = car_x_q;
  assign Car_Y       = car_y_q;
  assign Number_Cars = num_cars_q;
  assign frame_tick  = tick_q;
  assign running     = running_q;

endmodule

// File: tb/tb_car_row_mover.sv
// -----------------------------------------------------------------------------
// tb_car_row_mover
//
// Three instances share the clock, reset and frame strobe:
//   a: default parameters (move right, 4 cars, level 0)
//   b: DIR_LEFT=1, level 3 (speed 4)
//   c: N_CARS=2, started on the very cycle a frame tick is present
// -----------------------------------------------------------------------------
module tb_car_row_mover;

  logic Clk = 1'b0;
  logic clk_en = 1'b1;
  logic Reset;
  logic frame_clk;

  logic game_start_a, game_start_b, game_start_c;
  logic pause_a;
  logic [1:0] level_a, level_b;

  logic [3:0][10:0] car_x_a, car_y_a, car_x_b, car_y_b, car_x_c, car_y_c;
  logic [2:0] num_a, num_b, num_c;
  logic tick_a, tick_b, tick_c;
  logic run_a, run_b, run_c;

  int total = 0;
  int bad = 0;
  int tick_cnt = 0;
  int tick_base;

  always begin
    #5;
    if (clk_en) Clk = ~Clk;
  end

  always @(posedge Clk) begin
    if (tick_a) tick_cnt <= tick_cnt + 1;
  end

  car_row_mover u_a (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .game_start(game_start_a), .pause(pause_a), .level(level_a),
    .Car_X(car_x_a), .Car_Y(car_y_a), .Number_Cars(num_a),
    .frame_tick(tick_a), .running(run_a)
  );

  car_row_mover #(.DIR_LEFT(1'b1)) u_b (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .game_start(game_start_b), .pause(1'b0), .level(level_b),
    .Car_X(car_x_b), .Car_Y(car_y_b), .Number_Cars(num_b),
    .frame_tick(tick_b), .running(run_b)
  );

  car_row_mover #(.N_CARS(3'd2)) u_c (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .game_start(game_start_c), .pause(1'b0), .level(2'd0),
    .Car_X(car_x_c), .Car_Y(car_y_c), .Number_Cars(num_c),
    .frame_tick(tick_c), .running(run_c)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Pack four car values, index 3 first (matches [3:0][10:0] ordering).
  function automatic logic [43:0] px(input int a3, input int a2,
                                     input int a1, input int a0);
    px = {11'(a3), 11'(a2), 11'(a1), 11'(a0)};
  endfunction

  // One frame_clk pulse. tick checks are optional; gs_c pulses game_start_c
  // on the cycle where frame_tick is high.
  task automatic do_frame(input bit chk, input bit gs_c);
    @(posedge Clk); #1; frame_clk = 1'b1;
    @(posedge Clk); #1;                      // edge 1
    @(posedge Clk); #1;                      // edge 2
    if (chk) check("tick_before_e3", 64'(tick_a), 64'(0));
    @(posedge Clk); #1;                      // edge 3: tick appears
    if (chk) check("tick_at_e3", 64'(tick_a), 64'(1));
    if (gs_c) game_start_c = 1'b1;
    @(posedge Clk); #1;                      // edge 4: positions update
    game_start_c = 1'b0;
    if (chk) check("tick_after_e4", 64'(tick_a), 64'(0));
    @(posedge Clk); #1; frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) do_frame(1'b0, 1'b0);
  endtask

  initial begin
    Reset = 1'b1;
    frame_clk = 1'b0;
    game_start_a = 1'b0; game_start_b = 1'b0; game_start_c = 1'b0;
    pause_a = 1'b0;
    level_a = 2'd0; level_b = 2'd3;

    repeat (3) @(posedge Clk);
    #1;
    check("rst_x", 64'(car_x_a), 64'(0));
    check("rst_y", 64'(car_y_a), 64'(0));
    check("rst_num", 64'(num_a), 64'(0));
    check("rst_run", 64'(run_a), 64'(0));
    check("rst_tick", 64'(tick_a), 64'(0));
    Reset = 1'b0;

    // Idle: positions stay frozen through a frame.
    do_frame(1'b0, 1'b0);
    check("idle_x", 64'(car_x_a), 64'(0));
    check("idle_num", 64'(num_a), 64'(0));

    // Start lanes a and b.
    @(posedge Clk); #1;
    game_start_a = 1'b1; game_start_b = 1'b1;
    @(posedge Clk); #1;
    game_start_a = 1'b0; game_start_b = 1'b0;
    level_a = 2'd3;  // must not affect the running speed
    check("start_x_a", 64'(car_x_a), 64'(px(480, 320, 160, 0)));
    check("start_y_a", 64'(car_y_a), 64'(px(400, 400, 400, 400)));
    check("start_num_a", 64'(num_a), 64'(4));
    check("start_run_a", 64'(run_a), 64'(1));
    check("start_x_b", 64'(car_x_b), 64'(px(480, 320, 160, 0)));

    // Frame 1, with tick timing checks and lane c started on the tick.
    tick_base = tick_cnt;
    do_frame(1'b1, 1'b1);
    check("f1_tick_cnt", 64'(tick_cnt - tick_base), 64'(1));
    check("f1_x_a", 64'(car_x_a), 64'(px(481, 321, 161, 1)));
    check("f1_x_b", 64'(car_x_b), 64'(px(476, 316, 156, -4)));
    check("c_x", 64'(car_x_c), 64'(px(0, 0, 160, 0)));
    check("c_y", 64'(car_y_c), 64'(px(0, 0, 400, 400)));
    check("c_num", 64'(num_c), 64'(2));

    // Pause lane a for 10 frames.
    @(posedge Clk); #1;
    pause_a = 1'b1;
    @(posedge Clk); #1;
    check("pause_run", 64'(run_a), 64'(0));
    check("pause_num", 64'(num_a), 64'(4));
    tick_base = tick_cnt;
    do_frame(1'b0, 1'b0);
    check("c_moved", 64'(car_x_c), 64'(px(0, 0, 161, 1)));
    frames(9);
    check("pause_x_a", 64'(car_x_a), 64'(px(481, 321, 161, 1)));
    check("pause_ticks", 64'(tick_cnt - tick_base), 64'(10));
    pause_a = 1'b0;
    @(posedge Clk); #1;
    check("resume_run", 64'(run_a), 64'(1));
    do_frame(1'b0, 1'b0);
    check("resume_x_a", 64'(car_x_a), 64'(px(482, 322, 162, 2)));

    // Lane b reaches its left wrap on its 20th frame.
    frames(7);
    check("b_f19", 64'(car_x_b), 64'(px(404, 244, 84, -76)));
    frames(1);
    check("b_f20_wrap", 64'(car_x_b), 64'(px(400, 240, 80, 640)));

    // Lane a: car 3 reaches the right threshold on move 160.
    frames(149);
    check("a_m159", 64'(car_x_a), 64'(px(639, 479, 319, 159)));
    frames(1);
    check("a_m160_wrap", 64'(car_x_a), 64'(px(1968, 480, 320, 160)));
    frames(3);
    check("a_m163", 64'(car_x_a), 64'(px(1971, 483, 323, 163)));

    // Reset while running with the clock stopped.
    @(posedge Clk); #2;
    clk_en = 1'b0;
    #20;
    Reset = 1'b1;
    #1;
    check("async_rst_x", 64'(car_x_a), 64'(0));
    check("async_rst_y", 64'(car_y_a), 64'(0));
    check("async_rst_num", 64'(num_a), 64'(0));
    check("async_rst_run", 64'(run_a), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/car_row_mover.md
Name: car_row_mover

Overview:
- Generates per-frame X/Y positions for one lane of traffic (up to 4 cars) that the VGA colour mapping stage consumes.
- Lane convention: Car_X / Car_Y / Number_Cars feed one Car_RowN_X / Car_RowN_Y / RowN_Number_Cars group.
- Cars advance once per VGA frame and wrap horizontally using an 11-bit two's-complement off-screen convention.
- Lane level, start and pause are driven by game control.

Parameters:
- N_CARS, 3'd4, active cars (1..4); slots >= N_CARS held at X=0.
- ROW_Y, 11'd400, Y of every car in the lane.
- START_X, 11'd0, X of car 0 at start.
- SPACING, 11'd160, X offset between consecutive cars at start.
- BASE_SPEED, 4'd1, pixels/frame at level 0.
- DIR_LEFT, 1'b0, 0 = move right, 1 = move left.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  VGA frame strobe, asynchronous to Clk, one rising edge per frame
- game_start  in  1  one-cycle pulse: reload positions, enter RUN
- pause  in  1  level: freeze motion while high
- level  in  2  difficulty; sampled on game_start
- Car_X  out  [3:0][10:0]  car X positions, two's-complement 11-bit
- Car_Y  out  [3:0][10:0]  car Y positions
- Number_Cars  out  3  cars to draw; 0 when idle
- frame_tick  out  1  one-Clk pulse per detected frame_clk rise
- running  out  1  high in RUN

Behaviour:
Reset (async, immediate):
- state=IDLE; Car_X[i]=0; Car_Y[i]=0; Number_Cars=0; frame_tick=0; running=0.
- speed=BASE_SPEED; sync/edge flops=0.

Frame edge detect:
- frame_clk passes two sync flops (s1, s2), then prev<=s2.
- frame_tick = s2 & ~prev, registered so it is a clean 1-Clk pulse.
- frame_tick is high after the 3rd Clk edge following the frame_clk rise. Positions update on the Clk edge where frame_tick==1.
- frame_tick pulses in all states; exactly one pulse per frame_clk rise.

States IDLE, RUN, PAUSED:
- Any state, game_start=1 → RUN. On that edge:
  - Car_X[i] = START_X + i*SPACING (mod 2^11) for i<N_CARS, else 0.
  - Car_Y[i] = ROW_Y for i<N_CARS, else 0.
  - speed = BASE_SPEED + level (5-bit, no saturation).
- RUN & pause=1 & !game_start → PAUSED.
- PAUSED & pause=0 & !game_start → RUN.
- Number_Cars = N_CARS in RUN/PAUSED, 0 in IDLE. running = (state==RUN). Outputs registered.

Motion (RUN, frame_tick=1, game_start=0):
- Each active car, X interpreted as signed 11-bit (sx).
- Right (DIR_LEFT=0): if sx+speed >= 640 then X=11'd1968 (-80), else X=sx+speed.
- Left (DIR_LEFT=1): if sx-speed <= -80 then X=11'd640, else X=sx-speed.
- Car_Y unchanged. Inactive slots remain 0.

Boundary conditions:
- game_start same cycle as frame_tick: reload wins; no motion applied that frame.
- pause rising same cycle as frame_tick in RUN: motion applied, then PAUSED.
- PAUSED/IDLE: positions frozen through any number of ticks.
- Reset mid-frame: all outputs 0; next detected edge needs a fresh frame_clk rise after Reset release (prev=0, s2=0 → no spurious tick if frame_clk is already high? Yes: s2 goes 1 while prev is 0 gives one tick; this tick is allowed and ignored in IDLE).
- level changes outside game_start: no effect.

Test Plan:
- Reset asserted mid-RUN with Clk stopped → all outputs 0 immediately, Number_Cars=0, running=0.
- Defaults, level=0, game_start → Car_X = {480,320,160,0}, Car_Y all 400, Number_Cars=4. After 1 frame_clk rise → {481,321,161,1}, with frame_tick pulsing exactly once, 3 Clk edges after the rise.
- Defaults, 160 frames → car 3 reaches 640 threshold → Car_X[3]=1968; +3 frames (speed 1) → 1971.
- DIR_LEFT=1, START_X=0, level=3 (speed 4), game_start: Car_X[0]=0 → after 20 frames -80 hit → 640; others unaffected until their own wrap.
- pause=1 for 10 frames in RUN → X unchanged, frame_tick still 10 pulses; pause=0 → next frame moves by speed.
- N_CARS=2, game_start coincident with frame_tick → Car_X={0,0,160,0}, Car_Y={0,0,400,400}, no motion that frame, Number_Cars=2.
